// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: hazard/stall controller for a classic 5-stage pipeline.
// Arbitrates between data-memory wait, taken-branch flush, load-use stall and
// normal run. Control outputs are combinational from state and inputs.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   IFID_rs/IFID_rt          source registers of the instruction in IF/ID
//   IDEX_rt, IDEX_MemRead    destination and load flag of the instruction in ID/EX
//   EXMEM_branch_taken       resolved taken branch in EX/MEM
//   mem_req, mem_ready       data memory handshake in MEM
//   PC_write, IFID_write     PC / IF/ID write enables
//   IFID_flush, IDEX_bubble  IF/ID clear, ID/EX NOP insertion
//   EXMEM_hold               hold EX/MEM and MEM/WB
//   mem_timeout              sticky memory timeout flag
//   stall_cnt                saturating count of cycles with PC_write=0
module pipeline_stall_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT       = 255,
  localparam int unsigned REG_W = 5,
  localparam int unsigned CNT_W = 16,
  localparam int unsigned LD_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IFID_rs,
  input  logic [REG_W-1:0] IFID_rt,
  input  logic [REG_W-1:0] IDEX_rt,
  input  logic             IDEX_MemRead,
  input  logic             EXMEM_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IFID_flush,
  output logic             IDEX_bubble,
  output logic             EXMEM_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  state_t           ret_state_q, ret_state_d;
  state_t           cur_state_c;
  logic [LD_W-1:0]  ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             mem_wait_c;
  logic             hazard_c;

  assign mem_wait_c = mem_req && !mem_ready;

  // Load-use hazard; r0 is hardwired zero and never creates a dependency.
  assign hazard_c = IDEX_MemRead && (IDEX_rt != '0) &&
                    ((IDEX_rt == IFID_rs) || (IDEX_rt == IFID_rt));

  // Once the memory wait resolves, behave as the interrupted state this same cycle.
  assign cur_state_c = (state_q == MEM_WAIT) ? ret_state_q : state_q;

  // Next-state and control outputs, priority: mem wait > branch > load-use > run.
  always_comb begin
    PC_write      = 1'b1;
    IFID_write    = 1'b1;
    IFID_flush    = 1'b0;
    IDEX_bubble   = 1'b0;
    EXMEM_hold    = 1'b0;
    state_d       = state_q;
    ret_state_d   = ret_state_q;
    ld_cnt_d      = ld_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;

    if (mem_wait_c) begin
      PC_write   = 1'b0;
      IFID_write = 1'b0;
      EXMEM_hold = 1'b1;
      state_d    = MEM_WAIT;
      if (state_q != MEM_WAIT) begin
        ret_state_d = state_q;
        wait_cnt_d  = '0;
      end else begin
        if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
        if ((17'(wait_cnt_q) + 17'd1) == 17'(MEM_TIMEOUT)) begin
          mem_timeout_d = 1'b1;
        end
      end
    end else if (EXMEM_branch_taken) begin
      IFID_flush  = 1'b1;
      IDEX_bubble = 1'b1;
      state_d     = RUN;
      ld_cnt_d    = '0;
    end else if (cur_state_c == LOAD_STALL) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IDEX_bubble = 1'b1;
      if (ld_cnt_q <= LD_W'(1)) begin
        state_d  = RUN;
        ld_cnt_d = '0;
      end else begin
        state_d  = LOAD_STALL;
        ld_cnt_d = ld_cnt_q - LD_W'(1);
      end
    end else if (hazard_c) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IDEX_bubble = 1'b1;
      if (LOAD_STALL_CYCLES <= 1) begin
        state_d = RUN;
      end else begin
        state_d  = LOAD_STALL;
        ld_cnt_d = LD_W'(LOAD_STALL_CYCLES - 1);
      end
    end else begin
      state_d = RUN;
    end
  end

  // Stall cycle counter saturates rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PC_write && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      ret_state_q   <= RUN;
      ld_cnt_q      <= '0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      ret_state_q   <= ret_state_d;
      ld_cnt_q      <= ld_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: two instances (single-cycle load stall with
// default timeout, three-cycle load stall with MEM_TIMEOUT=4) share inputs.
// Each vector selects which instance it checks.
module tb_pipeline_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] IFID_rs = '0, IFID_rt = '0, IDEX_rt = '0;
  logic       IDEX_MemRead = 1'b0, EXMEM_branch_taken = 1'b0;
  logic       mem_req = 1'b0, mem_ready = 1'b0;

  logic        pc_a, ifw_a, fl_a, bub_a, hold_a, tmo_a;
  logic [15:0] cnt_a;
  logic        pc_b, ifw_b, fl_b, bub_b, hold_b, tmo_b;
  logic [15:0] cnt_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(255)) dut_a (
    .clk(clk), .rst(rst),
    .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IDEX_rt(IDEX_rt),
    .IDEX_MemRead(IDEX_MemRead), .EXMEM_branch_taken(EXMEM_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .PC_write(pc_a), .IFID_write(ifw_a), .IFID_flush(fl_a),
    .IDEX_bubble(bub_a), .EXMEM_hold(hold_a), .mem_timeout(tmo_a),
    .stall_cnt(cnt_a)
  );

  pipeline_stall_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst),
    .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IDEX_rt(IDEX_rt),
    .IDEX_MemRead(IDEX_MemRead), .EXMEM_branch_taken(EXMEM_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .PC_write(pc_b), .IFID_write(ifw_b), .IFID_flush(fl_b),
    .IDEX_bubble(bub_b), .EXMEM_hold(hold_b), .mem_timeout(tmo_b),
    .stall_cnt(cnt_b)
  );

  // ctrl = {PC_write, IFID_write, IFID_flush, IDEX_bubble, EXMEM_hold, mem_timeout}
  typedef struct packed {
    logic        sel;
    logic        rst;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  xrt;
    logic        mr;
    logic        br;
    logic        req;
    logic        rdy;
    logic [5:0]  ctrl;
    logic [15:0] cnt;
  } vec_t;

  typedef struct packed {
    logic        sel;
    logic [5:0]  ctrl;
    logic [15:0] cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   tag = 0;

  function automatic vec_t mk(input logic sel, input logic r,
                              input int rs, input int rt, input int xrt,
                              input logic mr, input logic br,
                              input logic req, input logic rdy,
                              input logic [5:0] ctrl, input int cnt);
    vec_t v;
    v.sel = sel; v.rst = r;
    v.rs = 5'(rs); v.rt = 5'(rt); v.xrt = 5'(xrt);
    v.mr = mr; v.br = br; v.req = req; v.rdy = rdy;
    v.ctrl = ctrl; v.cnt = 16'(cnt);
    return v;
  endfunction

  // Pop the oldest expectation and compare it with the selected instance.
  task automatic check_out(input int id);
    exp_t        e;
    logic [5:0]  got_ctrl;
    logic [15:0] got_cnt;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL chk%0d scoreboard empty", id);
      return;
    end
    e = sb_q.pop_front();
    got_ctrl = e.sel ? {pc_b, ifw_b, fl_b, bub_b, hold_b, tmo_b}
                     : {pc_a, ifw_a, fl_a, bub_a, hold_a, tmo_a};
    got_cnt  = e.sel ? cnt_b : cnt_a;
    if (got_ctrl !== e.ctrl || got_cnt !== e.cnt) begin
      failures++;
      $display("FAIL chk%0d dut=%0d ctrl got=%b exp=%b stall_cnt got=%0d exp=%0d",
               id, e.sel, got_ctrl, e.ctrl, got_cnt, e.cnt);
    end
  endtask

  task automatic push_exp(input logic sel, input logic [5:0] ctrl, input logic [15:0] cnt);
    exp_t e;
    e.sel = sel; e.ctrl = ctrl; e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  // Drive one vector just after the rising edge, compare at the falling edge.
  task automatic apply(input vec_t v);
    rst = v.rst;
    IFID_rs = v.rs; IFID_rt = v.rt; IDEX_rt = v.xrt;
    IDEX_MemRead = v.mr; EXMEM_branch_taken = v.br;
    mem_req = v.req; mem_ready = v.rdy;
    push_exp(v.sel, v.ctrl, v.cnt);
    @(negedge clk);
    check_out(tag);
    tag++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Instance A: LOAD_STALL_CYCLES=1
    vecs.push_back(mk(0,0, 0,0,0, 0,0,0,0, 6'b110000, 0));
    vecs.push_back(mk(0,1, 0,0,0, 0,0,0,0, 6'b110000, 0));
    vecs.push_back(mk(0,1, 5,0,5, 1,0,0,0, 6'b000100, 0)); // hazard on rs
    vecs.push_back(mk(0,1, 0,0,0, 0,0,0,0, 6'b110000, 1)); // single bubble only
    vecs.push_back(mk(0,1, 0,0,0, 0,0,0,0, 6'b110000, 1));
    vecs.push_back(mk(0,1, 0,0,0, 1,0,0,0, 6'b110000, 1)); // r0 load, no stall
    vecs.push_back(mk(0,1, 0,0,0, 1,0,0,0, 6'b110000, 1));
    vecs.push_back(mk(0,1, 3,7,7, 1,0,0,0, 6'b000100, 1)); // hazard on rt
    vecs.push_back(mk(0,1, 3,7,7, 1,1,0,0, 6'b111100, 2)); // branch beats hazard
    vecs.push_back(mk(0,1, 0,0,0, 0,0,0,0, 6'b110000, 2));
    vecs.push_back(mk(0,1, 5,6,4, 1,0,0,0, 6'b110000, 2)); // no register match
    vecs.push_back(mk(0,1, 5,0,5, 0,0,0,0, 6'b110000, 2)); // match but not a load
    vecs.push_back(mk(0,1, 5,0,5, 1,1,1,0, 6'b000010, 2)); // mem wait beats all
    vecs.push_back(mk(0,1, 5,0,5, 1,0,1,1, 6'b000100, 3)); // wait ends, hazard same cycle
    vecs.push_back(mk(0,1, 0,0,0, 0,0,0,0, 6'b110000, 4));
    vecs.push_back(mk(0,1, 0,0,0, 0,0,1,1, 6'b110000, 4)); // ready access, no wait
    // Instance B: LOAD_STALL_CYCLES=3, MEM_TIMEOUT=4
    vecs.push_back(mk(1,0, 0,0,0, 0,0,0,0, 6'b110000, 0));
    vecs.push_back(mk(1,1, 5,0,5, 1,0,0,0, 6'b000100, 0)); // stall 1
    vecs.push_back(mk(1,1, 0,0,0, 0,0,1,0, 6'b000010, 1)); // wait during stall 2
    vecs.push_back(mk(1,1, 0,0,0, 0,0,1,0, 6'b000010, 2));
    vecs.push_back(mk(1,1, 0,0,0, 0,0,1,1, 6'b000100, 3)); // stall 2 resumes
    vecs.push_back(mk(1,1, 5,0,5, 1,0,0,0, 6'b000100, 4)); // stall 3, hazard ignored
    vecs.push_back(mk(1,1, 0,0,0, 0,0,0,0, 6'b110000, 5)); // 5 stall cycles total
    vecs.push_back(mk(1,1, 5,0,5, 1,0,0,0, 6'b000100, 5));
    vecs.push_back(mk(1,1, 0,0,0, 0,1,0,0, 6'b111100, 6)); // branch aborts stall
    vecs.push_back(mk(1,1, 0,0,0, 0,0,0,0, 6'b110000, 6));
    vecs.push_back(mk(1,0, 0,0,0, 0,0,0,0, 6'b110000, 0)); // timeout sequence
    vecs.push_back(mk(1,1, 0,0,0, 0,0,1,0, 6'b000010, 0));
    vecs.push_back(mk(1,1, 0,0,0, 0,0,1,0, 6'b000010, 1));
    vecs.push_back(mk(1,1, 0,0,0, 0,0,1,0, 6'b000010, 2));
    vecs.push_back(mk(1,1, 0,0,0, 0,0,1,0, 6'b000010, 3));
    vecs.push_back(mk(1,1, 0,0,0, 0,0,1,0, 6'b000010, 4));
    vecs.push_back(mk(1,1, 0,0,0, 0,0,1,0, 6'b000011, 5)); // timeout set
    vecs.push_back(mk(1,1, 0,0,0, 0,0,1,1, 6'b110001, 6)); // sticky after ready
    vecs.push_back(mk(1,1, 0,0,0, 0,0,0,0, 6'b110001, 6));
    vecs.push_back(mk(1,0, 0,0,0, 0,0,0,0, 6'b110000, 0)); // cleared by reset
    vecs.push_back(mk(1,1, 0,0,0, 0,0,0,0, 6'b110000, 0));
    vecs.push_back(mk(1,1, 5,0,5, 1,0,0,0, 6'b000100, 0)); // reset mid-stall
    vecs.push_back(mk(1,0, 0,0,0, 0,0,0,0, 6'b110000, 0));
    vecs.push_back(mk(1,1, 0,0,0, 0,0,0,0, 6'b110000, 0)); // no residual stall
    vecs.push_back(mk(1,1, 0,0,0, 0,0,1,0, 6'b000010, 0)); // reset mid-wait
    vecs.push_back(mk(1,0, 5,0,5, 1,0,0,0, 6'b000100, 0)); // RUN rules during reset
    vecs.push_back(mk(1,1, 0,0,0, 0,0,0,0, 6'b110000, 0));

    @(posedge clk);
    #1;
    foreach (vecs[i]) apply(vecs[i]);

    // Saturation: continuous load-use hazard on instance A stalls every cycle.
    apply(mk(0,0, 0,0,0, 0,0,0,0, 6'b110000, 0));
    rst = 1'b1;
    IFID_rs = 5'd9; IFID_rt = 5'd0; IDEX_rt = 5'd9;
    IDEX_MemRead = 1'b1; EXMEM_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
    push_exp(1'b0, 6'b000100, 16'd65534);
    repeat (65534) @(posedge clk);
    @(negedge clk);
    check_out(tag); tag++;
    push_exp(1'b0, 6'b000100, 16'hFFFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_out(tag); tag++;
    push_exp(1'b0, 6'b000100, 16'hFFFF);
    repeat (4464) @(posedge clk);
    @(negedge clk);
    check_out(tag); tag++;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
